// File: rtl/cam_initiator.sv
// Request-side front end for a cam/tcam: clears all entries after reset, then issues
// tagged writes/searches and returns an ordered hit/miss response stream.
module cam_initiator #(
    parameter int CAM_WIDTH = 32,
    parameter int CAM_DEPTH = 16,
    parameter int CAM_LAT   = 1,
    parameter int TAG_WIDTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int WR_GAP    = 1,
    localparam int CAM_INDEX_WIDTH = $clog2(CAM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_op,
    input  logic                       cmd_vld,
    input  logic [CAM_INDEX_WIDTH-1:0] cmd_idx,
    input  logic [CAM_WIDTH-1:0]       cmd_data,
    input  logic [CAM_WIDTH-1:0]       cmd_mask,
    input  logic [TAG_WIDTH-1:0]       cmd_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_hit,
    output logic [CAM_INDEX_WIDTH-1:0] rsp_index,
    output logic [TAG_WIDTH-1:0]       rsp_tag,
    output logic                       data_we,
    output logic                       data_vld,
    output logic [CAM_INDEX_WIDTH-1:0] data_idx,
    output logic [CAM_WIDTH-1:0]       data_i,
    output logic [CAM_WIDTH-1:0]       data_mask,
    input  logic                       index_rdy,
    input  logic [CAM_INDEX_WIDTH-1:0] index_o,
    output logic                       init_done,
    output logic                       err_stray
);

    localparam int CNT_W = CAM_INDEX_WIDTH + 1;
    localparam int OUT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int GAP_W = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clr_cnt_q;
    logic [GAP_W-1:0]     gap_q;
    logic [OUT_W-1:0]     out_cnt_q;

    logic                       we_d, vld_d;
    logic [CAM_INDEX_WIDTH-1:0] idx_d;
    logic [CAM_WIDTH-1:0]       di_d, dm_d;

    logic accept, wr_acc, srch_acc, pop, push, exit_vld;

    // Stage 0 lines up with the search on the CAM port; stage CAM_LAT meets index_rdy.
    logic [CAM_LAT:0]     tok_vld_q;
    logic [TAG_WIDTH-1:0] tok_tag_q [CAM_LAT+1];

    logic                       cap_vld_q, cap_hit_q;
    logic [CAM_INDEX_WIDTH-1:0] cap_idx_q;
    logic [TAG_WIDTH-1:0]       cap_tag_q;

    logic                       fifo_hit [RES_DEPTH];
    logic [CAM_INDEX_WIDTH-1:0] fifo_idx [RES_DEPTH];
    logic [TAG_WIDTH-1:0]       fifo_tag [RES_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [OUT_W-1:0]           fifo_cnt_q;

    assign cmd_ready = (state_q == ST_RUN) && (out_cnt_q < OUT_W'(RES_DEPTH)) && (gap_q == '0);
    assign accept    = cmd_valid & cmd_ready;
    assign wr_acc    = accept & cmd_op;
    assign srch_acc  = accept & ~cmd_op;
    assign init_done = (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        vld_d   = 1'b0;
        idx_d   = '0;
        di_d    = '0;
        dm_d    = '0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == CNT_W'(CAM_DEPTH)) begin
                    state_d = ST_RUN;
                end else begin
                    we_d  = 1'b1;
                    idx_d = clr_cnt_q[CAM_INDEX_WIDTH-1:0];
                end
            end
            ST_RUN: begin
                if (wr_acc) begin
                    we_d  = 1'b1;
                    vld_d = cmd_vld;
                    idx_d = cmd_idx;
                    di_d  = cmd_data;
                    dm_d  = cmd_mask;
                end else if (srch_acc) begin
                    di_d = cmd_data;
                    dm_d = cmd_mask;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            gap_q     <= '0;
            data_we   <= 1'b0;
            data_vld  <= 1'b0;
            data_idx  <= '0;
            data_i    <= '0;
            data_mask <= '0;
        end else begin
            state_q   <= state_d;
            data_we   <= we_d;
            data_vld  <= vld_d;
            data_idx  <= idx_d;
            data_i    <= di_d;
            data_mask <= dm_d;
            if (state_q == ST_CLEAR && clr_cnt_q != CNT_W'(CAM_DEPTH))
                clr_cnt_q <= clr_cnt_q + 1'b1;
            if (wr_acc)
                gap_q <= GAP_W'(WR_GAP);
            else if (gap_q != '0)
                gap_q <= gap_q - 1'b1;
        end
    end

    assign exit_vld = tok_vld_q[CAM_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tok_vld_q <= '0;
            for (int i = 0; i <= CAM_LAT; i++) tok_tag_q[i] <= '0;
            cap_vld_q <= 1'b0;
            cap_hit_q <= 1'b0;
            cap_idx_q <= '0;
            cap_tag_q <= '0;
            err_stray <= 1'b0;
        end else begin
            tok_vld_q[0] <= srch_acc;
            tok_tag_q[0] <= cmd_tag;
            for (int i = 1; i <= CAM_LAT; i++) begin
                tok_vld_q[i] <= tok_vld_q[i-1];
                tok_tag_q[i] <= tok_tag_q[i-1];
            end
            cap_vld_q <= exit_vld;
            cap_hit_q <= exit_vld & index_rdy;
            cap_idx_q <= (exit_vld & index_rdy) ? index_o : '0;
            cap_tag_q <= tok_tag_q[CAM_LAT];
            if (index_rdy && !exit_vld)
                err_stray <= 1'b1;
        end
    end

    // Credits count a search from acceptance until its response is popped, so the
    // FIFO can never be pushed while full.
    assign push = cap_vld_q;
    assign pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_hit[wr_ptr_q] <= cap_hit_q;
            fifo_idx[wr_ptr_q] <= cap_idx_q;
            fifo_tag[wr_ptr_q] <= cap_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(RES_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            case ({srch_acc, pop})
                2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
                2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
                default: out_cnt_q <= out_cnt_q;
            endcase
        end
    end

    assign rsp_valid = (fifo_cnt_q != '0);
    assign rsp_hit   = rsp_valid & fifo_hit[rd_ptr_q];
    assign rsp_index = rsp_valid ? fifo_idx[rd_ptr_q] : '0;
    assign rsp_tag   = rsp_valid ? fifo_tag[rd_ptr_q] : '0;

endmodule

// File: doc/cam_initiator.md
# cam_initiator

Request-side front end for the `cam`/`tcam` blocks. It accepts tagged write and search commands over a valid/ready port and clears every CAM entry after reset. It drives the CAM's `data_we`/`data_vld`/`data_idx`/`data_i`/`data_mask` port and turns the CAM's hit-only `index_rdy`/`index_o` result into an ordered hit/miss response stream with tags and backpressure.

## Interface
Parameters:
- `CAM_WIDTH`, 32: key/mask width.
- `CAM_DEPTH`, 16: number of CAM entries. `CAM_INDEX_WIDTH = $clog2(CAM_DEPTH)` is derived.
- `CAM_LAT`, 1: cycles from a search being presented on the CAM port to `index_rdy` being sampled. Must be ≥1.
- `TAG_WIDTH`, 4: command tag width.
- `RES_DEPTH`, 4: response FIFO depth, which is also the search credit limit.
- `WR_GAP`, 1: bubble cycles forced after each accepted write.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command valid.
- `cmd_ready`  out  1  command accepted on `cmd_valid & cmd_ready`.
- `cmd_op`  in  1  command type: 0 = search, 1 = write.
- `cmd_vld`  in  1  entry valid bit (writes only).
- `cmd_idx`  in  CAM_INDEX_WIDTH  target entry (writes only).
- `cmd_data`  in  CAM_WIDTH  key.
- `cmd_mask`  in  CAM_WIDTH  mask.
- `cmd_tag`  in  TAG_WIDTH  tag, returned with the search response.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed on `rsp_valid & rsp_ready`.
- `rsp_hit`  out  1  1 = match found.
- `rsp_index`  out  CAM_INDEX_WIDTH  matching entry on a hit; 0 on a miss.
- `rsp_tag`  out  TAG_WIDTH  tag of the originating search.
- `data_we`, `data_vld`  out  1  CAM write enable and entry valid bit.
- `data_idx`  out  CAM_INDEX_WIDTH  CAM entry index.
- `data_i`, `data_mask`  out  CAM_WIDTH  CAM key and mask.
- `index_rdy`  in  1  CAM hit strobe.
- `index_o`  in  CAM_INDEX_WIDTH  CAM hit index.
- `init_done`  out  1  clear sweep complete.
- `err_stray`  out  1  sticky error: `index_rdy` sampled with no search in that slot.

## Operation
- All CAM-side outputs are registered.
- FSM has two states: CLEAR and RUN.
- Reset (`rst_n` = 0 at an edge):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - In-flight tokens, FIFO and credit count are emptied.
  - All outputs are 0.
- CLEAR:
  - One write per cycle for entries 0..CAM_DEPTH-1 in order: `data_we`=1, `data_vld`=0, `data_i`=0, `data_mask`=0, `data_idx`=counter.
  - `cmd_ready`=0 throughout.
  - After entry CAM_DEPTH-1 the FSM goes to RUN, with `init_done`=1 from then on.
- RUN, accepted write: the next CAM cycle drives `data_we`=1 and `data_vld`/`data_idx`/`data_i`/`data_mask` = `cmd_vld`/`cmd_idx`/`cmd_data`/`cmd_mask`. No response is produced.
- RUN, accepted search:
  - The next CAM cycle drives `data_we`=0, `data_vld`=0, `data_idx`=0, `data_i`=`cmd_data`, `data_mask`=`cmd_mask`.
  - A token {tag} enters a CAM_LAT-deep delay line.
- Idle CAM cycles drive `data_we`=0 and all other CAM outputs 0.
- When a token exits the delay line, the FIFO is pushed with:
  - `index_rdy`=1: {hit=1, index=`index_o`, tag}.
  - `index_rdy`=0: {hit=0, index=0, tag}.
- `index_rdy`=1 when no token exits sets `err_stray`, which stays set until reset. Nothing is pushed.
- Credits: `outstanding` = tokens in flight + FIFO occupancy.
- `cmd_ready` = RUN & (`outstanding` < RES_DEPTH) & (gap counter = 0).
  - This applies to writes as well: the block keeps one ready rule for all command types.
- An accepted write loads the gap counter with WR_GAP. The counter decrements to 0, one per cycle.
  - WR_GAP guarantees a search never overtakes a write in the CAM.
- Responses leave strictly in search-acceptance order; the FIFO head drives the `rsp_*` outputs.

## Timing
- Search accepted at edge t:
  - CAM port shows the search in cycle t..t+1.
  - Result is sampled at edge t+1+CAM_LAT.
  - `rsp_valid`=1 from edge t+2+CAM_LAT at the earliest, i.e. minimum latency CAM_LAT+2.
- Write accepted at edge t: `data_we`=1 in cycle t..t+1, and `cmd_ready`=0 for the next WR_GAP cycles.
- Clear sweep: `data_we`=1 for exactly CAM_DEPTH cycles, starting the first cycle after reset is released. `init_done` and `cmd_ready` may rise in the cycle after the last clear write.
- FIFO full with a pop and a push in the same cycle: both happen and occupancy is unchanged. The credit rule prevents overflow by construction.
- `rsp_*` outputs are stable while `rsp_valid` & !`rsp_ready`.
- Reset mid-operation: all in-flight searches are dropped with no stale response. `rsp_valid`=0 the cycle after the reset edge, and CLEAR re-runs.

## Test plan
- Release reset (defaults) → `data_we`=1 for 16 cycles with `data_idx` 0..15 and `data_vld`=0. `init_done`=1 and `cmd_ready`=1 on cycle 17; `cmd_ready`=0 before that.
- Write idx 3, key 0xDEADBEEF, mask 0xFFFFFFFF, vld 1, then search 0xDEADBEEF with tag 5 → `cmd_ready` drops for 1 cycle after the write. Response {hit=1, index=3, tag=5} arrives 3 cycles after search acceptance.
- Search 0x12345678 (absent), tag 7 → {hit=0, index=0, tag=7}, `err_stray`=0.
- `rsp_ready`=0, offer 6 searches with tags 0..5 → only tags 0..3 accepted, then `cmd_ready`=0. Setting `rsp_ready`=1 → responses drain in order 0,1,2,3, then tags 4,5 are accepted and responded.
- Force `index_rdy`=1 with no search in flight → `err_stray`=1 and stays 1, no response is pushed.
- Assert `rst_n`=0 for 1 cycle with 3 searches in flight → `rsp_valid`=0 the next cycle, the 16-cycle clear repeats, and none of the 3 tags is ever returned.
